// File: rtl/vga_timing_pkg.sv
// Purpose: shared 640x480@60 raster constants, counter/address widths, the
//          packed sync bundle carried through the delay line, and a small
//          window-compare helper.
// Ports:   none (package).
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned COLS     = H_ACTIVE / 8;
    localparam int unsigned ROWS     = V_ACTIVE / 8;

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned ADDR_W   = 14;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } sync_t;

    // True when lo <= pos < hi.
    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Purpose: WIDTH x DEPTH shift register; every stage resets asynchronously to
//          RESET_VAL so the output is defined while the pipe fills.
// Ports:   clock  in   shift clock
//          reset  in   async, active-high
//          din    in   WIDTH  value entering stage 0
//          dout   out  WIDTH  value leaving stage DEPTH-1
module sync_delay_line #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_char_timing.sv
// Purpose: free-running raster timing and character-address generator for the
//          80x60 text path. Registered address/sub-char/pixel outputs carry a
//          one-cycle latency; hsync/vsync/blank go through a PIPE_DLY-stage
//          delay line to line up with the character generator's pixel_on.
// Ports:   pixel_clock    in   pixel clock
//          reset          in   async, active-high
//          frame_restart  in   sync pulse, restarts the raster at (0,0)
//          char_address   out  14  row*COLS+col, 0 outside active area
//          subchar_line   out  3   v_count[2:0]
//          subchar_pixel  out  3   h_count[2:0]
//          pixel_x/y      out  10  h/v counters, undelayed
//          hsync/vsync    out  1   delayed by PIPE_DLY
//          blank          out  1   1 outside active area, delayed by PIPE_DLY
//          frame_start    out  1   pulse for position (0,0), undelayed
//          blink          out  1   toggles every BLINK_FR frames
module vga_char_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACT    = H_ACTIVE,
    parameter int unsigned H_FRONT  = H_FP,
    parameter int unsigned H_SYNC_W = H_SYNC,
    parameter int unsigned H_BACK   = H_BP,
    parameter int unsigned V_ACT    = V_ACTIVE,
    parameter int unsigned V_FRONT  = V_FP,
    parameter int unsigned V_SYNC_W = V_SYNC,
    parameter int unsigned V_BACK   = V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIPE_DLY = 10,
    parameter int unsigned BLINK_FR = 32
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              frame_restart,
    output logic [ADDR_W-1:0] char_address,
    output logic [2:0]        subchar_line,
    output logic [2:0]        subchar_pixel,
    output logic [CNT_W-1:0]  pixel_x,
    output logic [CNT_W-1:0]  pixel_y,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              frame_start,
    output logic              blink
);

    localparam int unsigned H_TOT = H_ACT + H_FRONT + H_SYNC_W + H_BACK;
    localparam int unsigned V_TOT = V_ACT + V_FRONT + V_SYNC_W + V_BACK;
    localparam int unsigned FC_W  = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

    localparam logic [CNT_W-1:0]  H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0]  V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0]  H_ACT_C  = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0]  V_ACT_C  = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0]  HS_START = CNT_W'(H_ACT + H_FRONT);
    localparam logic [CNT_W-1:0]  HS_END   = CNT_W'(H_ACT + H_FRONT + H_SYNC_W);
    localparam logic [CNT_W-1:0]  VS_START = CNT_W'(V_ACT + V_FRONT);
    localparam logic [CNT_W-1:0]  VS_END   = CNT_W'(V_ACT + V_FRONT + V_SYNC_W);
    localparam logic [ADDR_W-1:0] COLS_C   = ADDR_W'(H_ACT / 8);
    localparam logic [FC_W-1:0]   FC_LAST  = FC_W'(BLINK_FR - 1);

    logic [CNT_W-1:0]  h_q, h_d, h_cur;
    logic [CNT_W-1:0]  v_q, v_d, v_cur;
    logic [ADDR_W-1:0] row_base_q, row_base_d, row_cur;
    logic [ADDR_W-1:0] addr_d;
    logic [FC_W-1:0]   fc_q, fc_d;
    logic              blink_d;
    logic              h_end, v_end, active;
    sync_t             raw_sync, dly_sync;

    // frame_restart substitutes position (0,0) for the current counter state,
    // so every registered output and the delay line see a clean frame start
    // on the next cycle and the counters advance from there.
    always_comb begin
        h_cur   = frame_restart ? '0 : h_q;
        v_cur   = frame_restart ? '0 : v_q;
        row_cur = frame_restart ? '0 : row_base_q;

        h_end  = (h_cur == H_LAST);
        v_end  = (v_cur == V_LAST);
        active = (h_cur < H_ACT_C) && (v_cur < V_ACT_C);

        h_d        = h_end ? '0 : h_cur + 1'b1;
        v_d        = v_cur;
        row_base_d = row_cur;
        if (h_end) begin
            if (v_end) begin
                v_d        = '0;
                row_base_d = '0;
            end else begin
                v_d = v_cur + 1'b1;
                // Last scanline of a visible character row: advance one row.
                if ((v_cur[2:0] == 3'd7) && (v_cur < V_ACT_C)) begin
                    row_base_d = row_cur + COLS_C;
                end
            end
        end

        raw_sync.hsync = in_window(h_cur, HS_START, HS_END) ? HS_POL : ~HS_POL;
        raw_sync.vsync = in_window(v_cur, VS_START, VS_END) ? VS_POL : ~VS_POL;
        raw_sync.blank = ~active;

        addr_d = active ? row_cur + ADDR_W'(h_cur[CNT_W-1:3]) : '0;

        fc_d    = fc_q;
        blink_d = blink;
        if (h_end && v_end) begin
            if (fc_q == FC_LAST) begin
                fc_d    = '0;
                blink_d = ~blink;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            h_q           <= '0;
            v_q           <= '0;
            row_base_q    <= '0;
            char_address  <= '0;
            subchar_line  <= '0;
            subchar_pixel <= '0;
            pixel_x       <= '0;
            pixel_y       <= '0;
            frame_start   <= 1'b0;
            fc_q          <= '0;
            blink         <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            row_base_q    <= row_base_d;
            char_address  <= addr_d;
            subchar_line  <= v_cur[2:0];
            subchar_pixel <= h_cur[2:0];
            pixel_x       <= h_cur;
            pixel_y       <= v_cur;
            frame_start   <= (h_cur == '0) && (v_cur == '0);
            fc_q          <= fc_d;
            blink         <= blink_d;
        end
    end

    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL ({~HS_POL, ~VS_POL, 1'b1})
    ) u_sync_dly (
        .clock (pixel_clock),
        .reset (reset),
        .din   (raw_sync),
        .dout  (dly_sync)
    );

    assign hsync = dly_sync.hsync;
    assign vsync = dly_sync.vsync;
    assign blank = dly_sync.blank;

endmodule

// File: tb/tb_vga_char_timing.sv
// Purpose: randomized self-checking bench. Two instances share clock, reset and
//          frame_restart: one at the default 640x480 timing, one with a tiny
//          raster so whole frames, row wraps and blink toggles fit the run.
//          The reference model tracks a linear position within the frame and
//          derives every output from it with plain arithmetic.
module tb_vga_char_timing;

    logic pixel_clock = 1'b0;
    logic reset;
    logic frame_restart;

    logic [13:0] o_addr  [2];
    logic [2:0]  o_sline [2];
    logic [2:0]  o_spix  [2];
    logic [9:0]  o_px    [2];
    logic [9:0]  o_py    [2];
    logic        o_hs    [2];
    logic        o_vs    [2];
    logic        o_bl    [2];
    logic        o_fs    [2];
    logic        o_bk    [2];

    always #5 pixel_clock = ~pixel_clock;

    vga_char_timing u_dflt (
        .pixel_clock   (pixel_clock),
        .reset         (reset),
        .frame_restart (frame_restart),
        .char_address  (o_addr[0]),
        .subchar_line  (o_sline[0]),
        .subchar_pixel (o_spix[0]),
        .pixel_x       (o_px[0]),
        .pixel_y       (o_py[0]),
        .hsync         (o_hs[0]),
        .vsync         (o_vs[0]),
        .blank         (o_bl[0]),
        .frame_start   (o_fs[0]),
        .blink         (o_bk[0])
    );

    vga_char_timing #(
        .H_ACT    (64),
        .H_FRONT  (4),
        .H_SYNC_W (8),
        .H_BACK   (4),
        .V_ACT    (24),
        .V_FRONT  (2),
        .V_SYNC_W (2),
        .V_BACK   (3),
        .HS_POL   (1'b1),
        .VS_POL   (1'b0),
        .PIPE_DLY (3),
        .BLINK_FR (2)
    ) u_tiny (
        .pixel_clock   (pixel_clock),
        .reset         (reset),
        .frame_restart (frame_restart),
        .char_address  (o_addr[1]),
        .subchar_line  (o_sline[1]),
        .subchar_pixel (o_spix[1]),
        .pixel_x       (o_px[1]),
        .pixel_y       (o_py[1]),
        .hsync         (o_hs[1]),
        .vsync         (o_vs[1]),
        .blank         (o_bl[1]),
        .frame_start   (o_fs[1]),
        .blink         (o_bk[1])
    );

    // Per-instance timing, index 0 = default, 1 = tiny.
    int unsigned c_ha  [2] = '{640, 64};
    int unsigned c_hfp [2] = '{16, 4};
    int unsigned c_hsw [2] = '{96, 8};
    int unsigned c_hbp [2] = '{48, 4};
    int unsigned c_va  [2] = '{480, 24};
    int unsigned c_vfp [2] = '{10, 2};
    int unsigned c_vsw [2] = '{2, 2};
    int unsigned c_vbp [2] = '{33, 3};
    int unsigned c_dly [2] = '{10, 3};
    int unsigned c_bfr [2] = '{32, 2};
    bit          c_hp  [2] = '{1'b0, 1'b1};
    bit          c_vp  [2] = '{1'b0, 1'b0};

    // Model state.
    int unsigned m_pos      [2];
    int unsigned m_edges    [2];
    int unsigned m_frames   [2];
    int unsigned m_last_cur [2];
    logic [2:0]  m_hist     [2][16];

    // Expected outputs.
    logic [13:0] e_addr  [2];
    logic [2:0]  e_sline [2];
    logic [2:0]  e_spix  [2];
    logic [9:0]  e_px    [2];
    logic [9:0]  e_py    [2];
    logic        e_hs    [2];
    logic        e_vs    [2];
    logic        e_bl    [2];
    logic        e_fs    [2];
    logic        e_bk    [2];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic string tg(input int i, input string s);
        return {(i == 0) ? "dflt." : "tiny.", s};
    endfunction

    function automatic int unsigned h_tot(input int i);
        return c_ha[i] + c_hfp[i] + c_hsw[i] + c_hbp[i];
    endfunction

    function automatic int unsigned v_tot(input int i);
        return c_va[i] + c_vfp[i] + c_vsw[i] + c_vbp[i];
    endfunction

    // {hsync, vsync, blank} for a frame position, before any delay.
    function automatic logic [2:0] raw_of(input int i, input int unsigned pos);
        int unsigned h, v;
        logic hs, vs, bl;
        h  = pos % h_tot(i);
        v  = pos / h_tot(i);
        hs = (h >= c_ha[i] + c_hfp[i] && h < c_ha[i] + c_hfp[i] + c_hsw[i]) ? c_hp[i] : !c_hp[i];
        vs = (v >= c_va[i] + c_vfp[i] && v < c_va[i] + c_vfp[i] + c_vsw[i]) ? c_vp[i] : !c_vp[i];
        bl = !(h < c_ha[i] && v < c_va[i]);
        return {hs, vs, bl};
    endfunction

    task automatic model_reset(input int i);
        m_pos[i]    = 0;
        m_edges[i]  = 0;
        m_frames[i] = 0;
        e_addr[i]   = '0;
        e_sline[i]  = '0;
        e_spix[i]   = '0;
        e_px[i]     = '0;
        e_py[i]     = '0;
        e_hs[i]     = !c_hp[i];
        e_vs[i]     = !c_vp[i];
        e_bl[i]     = 1'b1;
        e_fs[i]     = 1'b0;
        e_bk[i]     = 1'b0;
    endtask

    task automatic model_edge(input int i, input bit r);
        int unsigned cur, h, v, ft;
        logic [2:0] d;
        ft  = h_tot(i) * v_tot(i);
        cur = r ? 0 : m_pos[i];
        m_last_cur[i] = cur;
        h = cur % h_tot(i);
        v = cur / h_tot(i);
        e_px[i]    = 10'(h);
        e_py[i]    = 10'(v);
        e_spix[i]  = 3'(h % 8);
        e_sline[i] = 3'(v % 8);
        e_addr[i]  = (h < c_ha[i] && v < c_va[i]) ? 14'((v / 8) * (c_ha[i] / 8) + h / 8) : 14'd0;
        e_fs[i]    = (cur == 0);
        m_edges[i]++;
        m_hist[i][4'(m_edges[i])] = raw_of(i, cur);
        if (m_edges[i] < c_dly[i]) d = {!c_hp[i], !c_vp[i], 1'b1};
        else d = m_hist[i][4'(m_edges[i] - c_dly[i] + 1)];
        {e_hs[i], e_vs[i], e_bl[i]} = d;
        if (cur == ft - 1) m_frames[i]++;
        m_pos[i] = (cur + 1) % ft;
        e_bk[i]  = ((m_frames[i] / c_bfr[i]) % 2) == 1;
    endtask

    task automatic check_outputs(input int i);
        check_eq(tg(i, "char_address"),  32'(o_addr[i]),  32'(e_addr[i]));
        check_eq(tg(i, "subchar_line"),  32'(o_sline[i]), 32'(e_sline[i]));
        check_eq(tg(i, "subchar_pixel"), 32'(o_spix[i]),  32'(e_spix[i]));
        check_eq(tg(i, "pixel_x"),       32'(o_px[i]),    32'(e_px[i]));
        check_eq(tg(i, "pixel_y"),       32'(o_py[i]),    32'(e_py[i]));
        check_eq(tg(i, "hsync"),         32'(o_hs[i]),    32'(e_hs[i]));
        check_eq(tg(i, "vsync"),         32'(o_vs[i]),    32'(e_vs[i]));
        check_eq(tg(i, "blank"),         32'(o_bl[i]),    32'(e_bl[i]));
        check_eq(tg(i, "frame_start"),   32'(o_fs[i]),    32'(e_fs[i]));
        check_eq(tg(i, "blink"),         32'(o_bk[i]),    32'(e_bk[i]));
    endtask

    task automatic step(input bit r);
        frame_restart = r;
        @(posedge pixel_clock);
        for (int i = 0; i < 2; i++) model_edge(i, r);
        #1;
        for (int i = 0; i < 2; i++) check_outputs(i);
    endtask

    initial begin
        int unsigned hold;
        bit r;
        reset         = 1'b1;
        frame_restart = 1'b0;
        for (int i = 0; i < 2; i++) model_reset(i);
        repeat (3) @(posedge pixel_clock);
        #1;
        for (int i = 0; i < 2; i++) check_outputs(i);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) check_outputs(i);

        // Undisturbed run from reset: known raster positions.
        for (int k = 0; k < 7000; k++) begin
            step(1'b0);
            if (m_last_cur[0] == 8 * 800)     check_eq("dflt.addr_h0_v8", 32'(o_addr[0]), 80);
            if (m_last_cur[0] == 7 * 800 + 8) check_eq("dflt.addr_h8_v7", 32'(o_addr[0]), 1);
            if (m_last_cur[0] == 639)         check_eq("dflt.addr_h639_v0", 32'(o_addr[0]), 79);
            if (m_last_cur[0] == 640)         check_eq("dflt.addr_h640_v0", 32'(o_addr[0]), 0);
            if (m_last_cur[0] == 664)         check_eq("dflt.hsync_lag_pre", 32'(o_hs[0]), 1);
            if (m_last_cur[0] == 665)         check_eq("dflt.hsync_lag_fall", 32'(o_hs[0]), 0);
            if (m_last_cur[1] == 23 * 80 + 63) check_eq("tiny.addr_max", 32'(o_addr[1]), 23);
        end

        // Random restarts (single and held), plus one reset mid-frame.
        hold = 0;
        for (int k = 0; k < 30000; k++) begin
            if (hold > 0) begin
                r = 1'b1;
                hold--;
            end else if (k == 100 || $urandom_range(0, 9999) == 0) begin
                r = 1'b1;
            end else if (k == 300) begin
                r    = 1'b1;
                hold = 2;
            end else begin
                r = 1'b0;
            end
            step(r);
            if (r) begin
                check_eq("dflt.restart_px", 32'(o_px[0]), 0);
                check_eq("dflt.restart_py", 32'(o_py[0]), 0);
                check_eq("dflt.restart_addr", 32'(o_addr[0]), 0);
                check_eq("dflt.restart_fs", 32'(o_fs[0]), 1);
                if (hold == 0 && $urandom_range(0, 3) == 0) hold = $urandom_range(1, 3);
            end
            if (k == 15000) begin
                reset = 1'b1;
                #1;
                for (int i = 0; i < 2; i++) begin
                    model_reset(i);
                    check_outputs(i);
                end
                reset = 1'b0;
            end
        end

        frame_restart = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
